phy_rx_4b5b_deframer: RTL and testbench

- Receive-path stage directly downstream of the BMC decoder. Consumes its decoded bit stream (one bit per enable pulse).
- Hunts for symbol alignment, detects USB PD ordered sets, 4b5b-decodes payload symbols into bytes, and flags EOP or errors.
- Outputs feed the protocol-layer RX byte collector and CRC checker.

---
 rtl/phy_rx_4b5b_deframer.sv | 222 ++++++++++++++++++++++
 tb/tb_phy_rx_4b5b_deframer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_4b5b_deframer.sv
// USB PD receive deframer: hunts for symbol alignment on the decoded BMC bit
// stream, classifies ordered sets, 4b5b-decodes payload into bytes, flags EOP/errors.
module phy_rx_4b5b_deframer #(
    parameter int unsigned MAX_BYTES = 264
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_bit_in,
    input  logic       rx_bit_en,
    input  logic       rx_clr,
    output logic [7:0] rx_byte,
    output logic       rx_byte_en,
    output logic [2:0] rx_sop_type,
    output logic       rx_sop_en,
    output logic       rx_eop,
    output logic       rx_err
);
    localparam int unsigned CW = $clog2(MAX_BYTES + 1);

    localparam logic [4:0] K_S1  = 5'b11000;
    localparam logic [4:0] K_S2  = 5'b10001;
    localparam logic [4:0] K_S3  = 5'b00110;
    localparam logic [4:0] K_R1  = 5'b00111;
    localparam logic [4:0] K_R2  = 5'b11001;
    localparam logic [4:0] K_EOP = 5'b01101;

    typedef enum logic [1:0] {HUNT, ORDSET, DATA} state_t;

    state_t         state_q, state_d;
    logic [3:0]     sh_q, sh_d;
    logic [4:0]     win;
    logic [2:0]     bcnt_q, bcnt_d;
    logic [1:0]     kcnt_q, kcnt_d;
    logic [4:0]     k0_q, k0_d, k1_q, k1_d, k2_q, k2_d;
    logic           phase_q, phase_d;
    logic [3:0]     low_q, low_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     byte_d;
    logic [2:0]     sop_type_d;
    logic           byte_en_d, sop_en_d, eop_d, err_d;
    logic [4:0]     dec;
    logic           m_sop0, m_sop1, m_sop2, m_hr, m_cr;

    // Returns {valid, nibble}
    function automatic logic [4:0] decode(input logic [4:0] s);
        case (s)
            5'b11110: decode = 5'h10;
            5'b01001: decode = 5'h11;
            5'b10100: decode = 5'h12;
            5'b10101: decode = 5'h13;
            5'b01010: decode = 5'h14;
            5'b01011: decode = 5'h15;
            5'b01110: decode = 5'h16;
            5'b01111: decode = 5'h17;
            5'b10010: decode = 5'h18;
            5'b10011: decode = 5'h19;
            5'b10110: decode = 5'h1A;
            5'b10111: decode = 5'h1B;
            5'b11010: decode = 5'h1C;
            5'b11011: decode = 5'h1D;
            5'b11100: decode = 5'h1E;
            5'b11101: decode = 5'h1F;
            default:  decode = 5'h00;
        endcase
    endfunction

    function automatic logic match3(input logic [4:0] a0, a1, a2, a3,
                                    input logic [4:0] p0, p1, p2, p3);
        logic [2:0] n;
        n = 3'(a0 == p0) + 3'(a1 == p1) + 3'(a2 == p2) + 3'(a3 == p3);
        return n >= 3'd3;
    endfunction

    // The stored four bits are b4..b1 of the previous window; the new bit becomes b4
    assign win = {rx_bit_in, sh_q};
    assign dec = decode(win);

    assign m_sop0 = match3(k0_q, k1_q, k2_q, win, K_S1, K_S1, K_S1, K_S2);
    assign m_sop1 = match3(k0_q, k1_q, k2_q, win, K_S1, K_S1, K_S3, K_S3);
    assign m_sop2 = match3(k0_q, k1_q, k2_q, win, K_S1, K_S3, K_S1, K_S3);
    assign m_hr   = match3(k0_q, k1_q, k2_q, win, K_R1, K_R1, K_R1, K_R2);
    assign m_cr   = match3(k0_q, k1_q, k2_q, win, K_R1, K_S1, K_R1, K_S3);

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bcnt_d     = bcnt_q;
        kcnt_d     = kcnt_q;
        k0_d       = k0_q;
        k1_d       = k1_q;
        k2_d       = k2_q;
        phase_d    = phase_q;
        low_d      = low_q;
        cnt_d      = cnt_q;
        byte_d     = rx_byte;
        sop_type_d = rx_sop_type;
        byte_en_d  = 1'b0;
        sop_en_d   = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;

        if (rx_clr) begin
            state_d = HUNT;
            sh_d    = '0;
            bcnt_d  = '0;
            kcnt_d  = '0;
            phase_d = 1'b0;
            low_d   = '0;
            cnt_d   = '0;
        end else if (rx_bit_en) begin
            sh_d = win[4:1];
            case (state_q)
                HUNT: begin
                    if (win == K_S1 || win == K_R1) begin
                        k0_d    = win;
                        bcnt_d  = '0;
                        kcnt_d  = 2'd1;
                        state_d = ORDSET;
                    end
                end
                ORDSET: begin
                    if (bcnt_q != 3'd4) begin
                        bcnt_d = bcnt_q + 3'd1;
                    end else begin
                        bcnt_d = '0;
                        case (kcnt_q)
                            2'd1: begin k1_d = win; kcnt_d = 2'd2; end
                            2'd2: begin k2_d = win; kcnt_d = 2'd3; end
                            default: begin
                                kcnt_d  = '0;
                                state_d = HUNT;
                                // Resets outrank SOPs when a corrupted set matches several
                                if (m_hr) begin
                                    sop_type_d = 3'd3;
                                    sop_en_d   = 1'b1;
                                end else if (m_cr) begin
                                    sop_type_d = 3'd4;
                                    sop_en_d   = 1'b1;
                                end else if (m_sop0 || m_sop1 || m_sop2) begin
                                    sop_type_d = m_sop0 ? 3'd0 : (m_sop1 ? 3'd1 : 3'd2);
                                    sop_en_d   = 1'b1;
                                    phase_d    = 1'b0;
                                    cnt_d      = '0;
                                    state_d    = DATA;
                                end else begin
                                    sop_type_d = 3'd7;
                                    err_d      = 1'b1;
                                end
                            end
                        endcase
                    end
                end
                DATA: begin
                    if (bcnt_q != 3'd4) begin
                        bcnt_d = bcnt_q + 3'd1;
                    end else begin
                        bcnt_d = '0;
                        if (dec[4]) begin
                            if (!phase_q) begin
                                low_d   = dec[3:0];
                                phase_d = 1'b1;
                            end else if (cnt_q == CW'(MAX_BYTES)) begin
                                err_d   = 1'b1;
                                state_d = HUNT;
                            end else begin
                                byte_d    = {dec[3:0], low_q};
                                byte_en_d = 1'b1;
                                cnt_d     = cnt_q + CW'(1);
                                phase_d   = 1'b0;
                            end
                        end else if (win == K_EOP && !phase_q) begin
                            eop_d   = 1'b1;
                            state_d = HUNT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            sh_q        <= '0;
            bcnt_q      <= '0;
            kcnt_q      <= '0;
            k0_q        <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            phase_q     <= 1'b0;
            low_q       <= '0;
            cnt_q       <= '0;
            rx_byte     <= '0;
            rx_byte_en  <= 1'b0;
            rx_sop_type <= 3'd7;
            rx_sop_en   <= 1'b0;
            rx_eop      <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bcnt_q      <= bcnt_d;
            kcnt_q      <= kcnt_d;
            k0_q        <= k0_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            phase_q     <= phase_d;
            low_q       <= low_d;
            cnt_q       <= cnt_d;
            rx_byte     <= byte_d;
            rx_byte_en  <= byte_en_d;
            rx_sop_type <= sop_type_d;
            rx_sop_en   <= sop_en_d;
            rx_eop      <= eop_d;
            rx_err      <= err_d;
        end
    end
endmodule

// File: tb/tb_phy_rx_4b5b_deframer.sv
// Scoreboard bench for phy_rx_4b5b_deframer: directed symbol streams push expected
// output events; an independent monitor pops and checks kind, value and cycle.
module tb_phy_rx_4b5b_deframer;
    localparam int unsigned MAXB = 4;

    localparam logic [4:0] S1  = 5'b11000;
    localparam logic [4:0] S2  = 5'b10001;
    localparam logic [4:0] S3  = 5'b00110;
    localparam logic [4:0] R1  = 5'b00111;
    localparam logic [4:0] R2  = 5'b11001;
    localparam logic [4:0] EOP = 5'b01101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_bit_in = 1'b0;
    logic       rx_bit_en = 1'b0;
    logic       rx_clr = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_byte_en;
    logic [2:0] rx_sop_type;
    logic       rx_sop_en;
    logic       rx_eop;
    logic       rx_err;

    phy_rx_4b5b_deframer #(.MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .rx_bit_in(rx_bit_in), .rx_bit_en(rx_bit_en),
        .rx_clr(rx_clr), .rx_byte(rx_byte), .rx_byte_en(rx_byte_en),
        .rx_sop_type(rx_sop_type), .rx_sop_en(rx_sop_en), .rx_eop(rx_eop), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_NONE, EV_BYTE, EV_SOP, EV_EOP, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  data;
        int unsigned due;
    } ev_t;

    ev_t         sb[$];
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned gap = 0;

    // Hand-written 4b5b data table, nibble 0..F
    logic [4:0] enc [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                             5'b01010, 5'b01011, 5'b01110, 5'b01111,
                             5'b10010, 5'b10011, 5'b10110, 5'b10111,
                             5'b11010, 5'b11011, 5'b11100, 5'b11101};

    always @(posedge clk) cyc <= cyc + 1;

    int       npulse;
    ev_kind_t obs_kind;
    logic [7:0] obs_data;
    ev_t      exp_ev;

    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_%s: nothing seen at cycle %0d, required %s data=%h",
                         sb[0].kind.name(), sb[0].due, sb[0].kind.name(), sb[0].data);
                exp_ev = sb.pop_front();
            end
            npulse = int'(rx_byte_en) + int'(rx_sop_en) + int'(rx_eop) + int'(rx_err);
            if (npulse != 0) begin
                vectors++;
                obs_kind = rx_sop_en ? EV_SOP : (rx_eop ? EV_EOP : (rx_err ? EV_ERR : EV_BYTE));
                obs_data = rx_sop_en ? {5'd0, rx_sop_type} : (rx_byte_en ? rx_byte : 8'd0);
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_%s: got data=%h at cycle %0d, required no pulse",
                             obs_kind.name(), obs_data, cyc);
                end else begin
                    exp_ev = sb.pop_front();
                    if (npulse > 1 || exp_ev.kind != obs_kind || exp_ev.due != cyc
                        || exp_ev.data != obs_data) begin
                        miscompares++;
                        $display("FAIL event_%s: got %s data=%h pulses=%0d cycle=%0d, required %s data=%h cycle=%0d",
                                 exp_ev.kind.name(), obs_kind.name(), obs_data, npulse, cyc,
                                 exp_ev.kind.name(), exp_ev.data, exp_ev.due);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic b, input ev_kind_t k, input logic [7:0] d);
        @(negedge clk);
        rx_bit_in = b;
        rx_bit_en = 1'b1;
        if (k != EV_NONE) sb.push_back(ev_t'{kind: k, data: d, due: cyc + 1});
        @(posedge clk);
        #1 rx_bit_en = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // b0 of the table entry goes out first
    task automatic send_sym(input logic [4:0] c, input ev_kind_t k, input logic [7:0] d);
        for (int i = 0; i < 5; i++) send_bit(c[i], (i == 4) ? k : EV_NONE, d);
    endtask

    task automatic preamble();
        for (int i = 0; i < 64; i++) send_bit(1'(i % 2), EV_NONE, 8'd0);
    endtask

    task automatic ordset(input logic [4:0] a, b, c, d, input ev_kind_t k, input logic [7:0] t);
        preamble();
        send_sym(a, EV_NONE, 8'd0);
        send_sym(b, EV_NONE, 8'd0);
        send_sym(c, EV_NONE, 8'd0);
        send_sym(d, k, t);
    endtask

    task automatic do_clr(input logic with_bit, input logic b);
        @(negedge clk);
        rx_clr    = 1'b1;
        rx_bit_en = with_bit;
        rx_bit_in = b;
        @(posedge clk);
        #1 rx_clr = 1'b0;
        rx_bit_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_byte", rx_byte, 8'h00);
        check("reset_sop_type", {5'd0, rx_sop_type}, 8'd7);
        check("reset_pulses", {4'd0, rx_byte_en, rx_sop_en, rx_eop, rx_err}, 8'd0);
        @(negedge clk) rst_n = 1'b1;

        // Full packet: SOP, 0xA5, 0x3C, EOP
        ordset(S1, S1, S1, S2, EV_SOP, 8'd0);
        send_sym(enc[5],  EV_NONE, 8'd0);
        send_sym(enc[10], EV_BYTE, 8'hA5);
        send_sym(enc[12], EV_NONE, 8'd0);
        send_sym(enc[3],  EV_BYTE, 8'h3C);
        send_sym(EOP,     EV_EOP,  8'd0);

        // SOP and SOP' both reach 3-of-4; SOP wins by priority
        ordset(S1, S1, S3, S2, EV_SOP, 8'd0);
        send_sym(EOP, EV_EOP, 8'd0);

        // Only SOP' reaches 3-of-4; sparse bit enables
        gap = 1;
        ordset(S1, S2, S3, S3, EV_SOP, 8'd1);
        send_sym(EOP, EV_EOP, 8'd0);
        gap = 0;

        ordset(S1, S1, S1, S3, EV_SOP, 8'd0);
        send_sym(EOP, EV_EOP, 8'd0);
        ordset(S1, S3, S1, S3, EV_SOP, 8'd2);
        send_sym(EOP, EV_EOP, 8'd0);
        ordset(R1, S1, R1, S3, EV_SOP, 8'd4);

        // Hard Reset returns to HUNT: trailing data symbols are ignored
        ordset(R1, R1, R1, R2, EV_SOP, 8'd3);
        for (int i = 0; i < 4; i++) send_sym(enc[0], EV_NONE, 8'd0);

        // Odd nibble count before EOP
        ordset(S1, S1, S1, S2, EV_SOP, 8'd0);
        send_sym(enc[1], EV_NONE, 8'd0);
        send_sym(enc[2], EV_BYTE, 8'h21);
        send_sym(enc[3], EV_NONE, 8'd0);
        send_sym(EOP,    EV_ERR,  8'd0);

        // Invalid code in payload
        ordset(S1, S1, S1, S2, EV_SOP, 8'd0);
        send_sym(5'b00000, EV_ERR, 8'd0);

        // Unrecognisable ordered set
        ordset(S1, S2, S3, S2, EV_ERR, 8'd0);
        check("nomatch_sop_type", {5'd0, rx_sop_type}, 8'd7);

        // Byte limit: four bytes accepted, fifth errors
        ordset(S1, S1, S1, S2, EV_SOP, 8'd0);
        send_sym(enc[1], EV_NONE, 8'd0); send_sym(enc[2],  EV_BYTE, 8'h21);
        send_sym(enc[3], EV_NONE, 8'd0); send_sym(enc[4],  EV_BYTE, 8'h43);
        send_sym(enc[5], EV_NONE, 8'd0); send_sym(enc[6],  EV_BYTE, 8'h65);
        send_sym(enc[7], EV_NONE, 8'd0); send_sym(enc[8],  EV_BYTE, 8'h87);
        send_sym(enc[9], EV_NONE, 8'd0); send_sym(enc[10], EV_ERR,  8'd0);

        // Clear mid-byte, then a clean packet
        ordset(S1, S1, S1, S2, EV_SOP, 8'd0);
        send_sym(enc[15], EV_NONE, 8'd0);
        do_clr(1'b0, 1'b0);
        check("clr_holds_byte", rx_byte, 8'h87);
        check("clr_holds_sop_type", {5'd0, rx_sop_type}, 8'd0);
        ordset(S1, S1, S1, S2, EV_SOP, 8'd0);
        send_sym(enc[1], EV_NONE, 8'd0);
        send_sym(enc[1], EV_BYTE, 8'h11);
        send_sym(EOP,    EV_EOP,  8'd0);

        // Bit coincident with clear must be dropped: otherwise alignment is one bit early
        do_clr(1'b1, 1'b1);
        send_bit(1'b1, EV_NONE, 8'd0);
        send_bit(1'b1, EV_NONE, 8'd0);
        send_sym(S1, EV_NONE, 8'd0);
        send_sym(S1, EV_NONE, 8'd0);
        send_sym(S2, EV_SOP,  8'd0);
        send_sym(EOP, EV_EOP, 8'd0);

        // Asynchronous reset mid-packet
        ordset(S1, S1, S1, S2, EV_SOP, 8'd0);
        send_sym(enc[6], EV_NONE, 8'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_byte", rx_byte, 8'h00);
        check("async_rst_sop_type", {5'd0, rx_sop_type}, 8'd7);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);

        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
